// File: rtl/mtl2_multi_timer.sv
// mtl2_multi_timer: NUM_CH independent down-counting interval timers behind
// one 32-bit Avalon-MM slave (read latency 1).
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   address             word address; channel c at 4c..4c+3, IRQ_PEND at 4*NUM_CH
//   chipselect, write_n, read_n, writedata   Avalon-MM slave write/read
//   readdata            registered, valid the cycle after the address
//   irq_ch              per-channel interrupt (TO & ITO)
//   irq                 OR of irq_ch
//
// Channel register map (word offset within the channel):
//   0 STATUS   r: {RUN,TO}, any write clears TO
//   1 CONTROL  rw: ITO, CONT, START(strobe), STOP(strobe), PRE[15:8]
//   2 PERIOD   rw: CNT_W bits; a write stops the channel and reloads it
//   3 SNAPSHOT r: captured counter; any write captures the live counter

// One timer channel. Write strobes come pre-decoded from the top.
module mtl2_timer_ch #(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 19999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [31:0]      writedata,
  output logic             to,
  output logic             run,
  output logic [15:0]      control,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snapshot,
  output logic             irq
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] counter;
  logic [7:0]       pre_cnt;
  logic             reload_pend;  // PERIOD written last cycle: reload now
  logic             tick, wrap, start, stop;
  logic             unused_wd;

  // Only some writedata bits matter depending on the register and CNT_W.
  assign unused_wd = ^writedata;

  always_comb begin
    tick  = run && (pre_cnt == control[15:8]);
    wrap  = tick && (counter == '0);
    start = wr_control && writedata[2];
    stop  = wr_control && writedata[3];
  end

  assign irq = to & control[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      to          <= 1'b0;
      run         <= 1'b0;
      control     <= '0;
      period      <= DEF_P;
      counter     <= DEF_P;
      snapshot    <= '0;
      pre_cnt     <= '0;
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= wr_period;
      if (wr_control) control  <= {writedata[15:8], 4'b0000, writedata[3:0]};
      if (wr_period)  period   <= writedata[CNT_W-1:0];
      if (wr_snap)    snapshot <= counter;

      // A wrap on the clearing cycle wins so no timeout is lost.
      to <= wrap | (to & ~wr_status);

      // START beats STOP; a PERIOD write forces a stop.
      if (start)                  run <= 1'b1;
      else if (stop || wr_period) run <= 1'b0;
      else if (wrap)              run <= control[1];

      if (start || reload_pend) pre_cnt <= '0;
      else if (run)             pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;

      // Counter never underflows: zero reloads from PERIOD on the tick.
      if (reload_pend) counter <= period;
      else if (tick)   counter <= wrap ? period : counter - 1'b1;
    end
  end

endmodule

module mtl2_multi_timer #(
  parameter  int NUM_CH         = 4,
  parameter  int CNT_W          = 32,
  parameter  int DEFAULT_PERIOD = 19999,
  localparam int ADDR_W         = $clog2(4*NUM_CH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);

  logic                             wr;
  logic                             unused_rd;
  logic [NUM_CH-1:0]                to_v, run_v;
  logic [NUM_CH-1:0][15:0]          ctrl_v;
  logic [NUM_CH-1:0][CNT_W-1:0]     per_v, snap_v;
  logic [31:0]                      rd_next;

  assign wr        = chipselect & ~write_n;
  assign unused_rd = read_n;  // readdata is registered every cycle

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = wr && (address[ADDR_W-1:2] == (ADDR_W-2)'(c));

    mtl2_timer_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_status  (hit && address[1:0] == 2'd0),
      .wr_control (hit && address[1:0] == 2'd1),
      .wr_period  (hit && address[1:0] == 2'd2),
      .wr_snap    (hit && address[1:0] == 2'd3),
      .writedata  (writedata),
      .to         (to_v[c]),
      .run        (run_v[c]),
      .control    (ctrl_v[c]),
      .period     (per_v[c]),
      .snapshot   (snap_v[c]),
      .irq        (irq_ch[c])
    );
  end

  assign irq = |irq_ch;

  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (address[ADDR_W-1:2] == (ADDR_W-2)'(c)) begin
        case (address[1:0])
          2'd0: rd_next[1:0]       = {run_v[c], to_v[c]};
          2'd1: rd_next[15:0]      = ctrl_v[c];
          2'd2: rd_next[CNT_W-1:0] = per_v[c];
          default: rd_next[CNT_W-1:0] = snap_v[c];
        endcase
      end
    end
    if (address == ADDR_W'(4*NUM_CH)) rd_next[NUM_CH-1:0] = irq_ch;
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule

// File: tb/tb_mtl2_multi_timer.sv
// Bench for mtl2_multi_timer (4 channels, 16-bit counters). Reads push their
// expected value into a queue; a monitor compares readdata the cycle after.
module tb_mtl2_multi_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic              read_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_ch;
  logic              irq;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic rd_vld = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  mtl2_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(19999)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .irq_ch(irq_ch), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= chipselect & ~read_n & ~reset;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: readdata is valid one cycle after the read was issued.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_read: got %h expected none", readdata);
      end else begin
        chk(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    exp_q.push_back(e); name_q.push_back(nm);
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cycles from base until irq_ch[ch] is seen high (bounded).
  task automatic wait_irq(input int ch, input int base, input int exp_n, input string nm);
    int n = 0;
    while (!irq_ch[ch] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(cyc - base), 32'(exp_n));
  endtask

  int ts, t1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("irq_in_reset", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // Reset defaults
    rd(5'd2,  32'd19999, "ch0_period_default");
    rd(5'd0,  32'h0, "ch0_status_default");
    rd(5'd3,  32'h0, "ch0_snapshot_default");
    rd(5'd16, 32'h0, "irq_pend_default");
    chk("irq_default", {31'b0, irq}, 32'h0);

    // ch1 continuous, PERIOD=9, PRE=1 -> TO every 20 cycles
    wr(5'd6, 32'd9);
    wr(5'd5, 32'h0000_0107);
    ts = cyc;
    wait_irq(1, ts, 20, "ch1_first_timeout");
    t1 = cyc;
    rd(5'd4, 32'h3, "ch1_status_to_run");
    wr(5'd4, 32'h0);
    chk("ch1_irq_cleared", {28'b0, irq_ch}, 32'h0);
    wait_irq(1, t1, 20, "ch1_second_timeout");

    // ch2 one-shot, PERIOD=4
    wr(5'd10, 32'd4);
    wr(5'd9,  32'h4);
    idle(30);
    rd(5'd8,  32'h1, "ch2_oneshot_status");
    wr(5'd11, 32'h0);
    rd(5'd11, 32'd4, "ch2_reloaded_counter");
    wr(5'd8,  32'h0);
    idle(100);
    rd(5'd8,  32'h0, "ch2_no_second_timeout");

    // ch0 clear colliding with wrap: PERIOD=3, PRE=0, wraps 4 cycles after START
    wr(5'd2, 32'd3);
    wr(5'd1, 32'h6);
    idle(3);
    wr(5'd0, 32'h0);
    rd(5'd0, 32'h3, "ch0_collision_to_kept");
    wr(5'd0, 32'h0);
    rd(5'd0, 32'h2, "ch0_clear_after");
    wr(5'd1, 32'h8);

    // ch3 PERIOD write mid-count and snapshots
    wr(5'd13, 32'h6);
    idle(5);
    wr(5'd14, 32'd100);
    rd(5'd12, 32'h0, "ch3_period_write_stops");
    wr(5'd15, 32'h0);
    rd(5'd15, 32'd100, "ch3_snapshot_reloaded");
    wr(5'd13, 32'h6);
    idle(10);
    wr(5'd15, 32'h0);
    rd(5'd15, 32'd90, "ch3_snapshot_after_10");

    // Width, START+STOP, unmapped, independence
    wr(5'd14, 32'h1234_ABCD);
    rd(5'd14, 32'h0000_ABCD, "ch3_period_truncated");
    wr(5'd13, 32'hC);
    rd(5'd12, 32'h2, "ch3_start_beats_stop");
    rd(5'd13, 32'hC, "ch3_control_readback");
    rd(5'd17, 32'h0, "unmapped_17");
    wr(5'd20, 32'hFFFF_FFFF);
    rd(5'd31, 32'h0, "unmapped_31");
    rd(5'd16, 32'h2, "irq_pend_ch1");
    chk("irq_top_ch1", {31'b0, irq}, 32'h1);
    wr(5'd11, 32'h0);
    rd(5'd11, 32'd4, "ch2_counter_untouched");
    rd(5'd6,  32'd9, "ch1_period_untouched");

    // Clearing ITO drops the interrupt
    wr(5'd5, 32'h0000_0102);
    chk("ch1_irq_ito_off", {28'b0, irq_ch}, 32'h0);
    rd(5'd16, 32'h0, "irq_pend_ito_off");

    // Reset mid-count
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("irq_after_reset", {27'b0, irq, irq_ch}, 32'h0);
    rd(5'd4, 32'h0, "ch1_status_after_reset");
    rd(5'd6, 32'd19999, "ch1_period_after_reset");
    rd(5'd7, 32'h0, "ch1_snapshot_after_reset");

    idle(3);
    if (exp_q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL read_queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
